// File: rtl/demux2_router_if.sv
// ----------------------------------------------------------------------------
// demux2_router_if.sv
// Handshake bundles used by demux2_router.
//
// demux2_in_if  : producer -> router word stream.
//   valid   producer offers a word
//   ready   router accepts the word (transfer = valid & ready)
//   select  0 -> destination A, 1 -> destination B
//   data    payload, DW bits
//   addr    register address travelling with the payload, AW bits
//   modport master : producer side, slave : router side
//
// demux2_out_if : router -> sink word stream (one per destination).
//   valid   port holds a word
//   ready   sink takes the word (transfer = valid & ready)
//   data    payload, DW bits
//   addr    register address, AW bits
//   modport master : router side, slave : sink side
// ----------------------------------------------------------------------------

interface demux2_in_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          valid;
    logic          ready;
    logic          select;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;

    modport master (
        output valid,
        output select,
        output data,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  select,
        input  data,
        input  addr,
        output ready
    );
endinterface

interface demux2_out_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;

    modport master (
        output valid,
        output data,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  addr,
        output ready
    );
endinterface

// File: rtl/demux2_router.sv
// ----------------------------------------------------------------------------
// demux2_router.sv
// 1-to-2 registered demultiplexer. Each accepted {data, addr} word is steered
// to destination A (select=0) or B (select=1) and held in that port's
// one-entry output register until its sink takes it. A stall on one sink
// never disturbs the other port.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   in_if      demux2_in_if.slave   producer stream (valid/ready/select/data/addr)
//   a_if       demux2_out_if.master destination A (valid/ready/data/addr)
//   b_if       demux2_out_if.master destination B (valid/ready/data/addr)
//   a_count    16-bit count of A sink transfers   (only with DEMUX2_ROUTER_COUNT_EN)
//   b_count    16-bit count of B sink transfers   (only with DEMUX2_ROUTER_COUNT_EN)
//
// Optional feature macro: DEMUX2_ROUTER_COUNT_EN
//   Defined   -> per-port sink-transfer counters, wrapping 16'hFFFF -> 0.
//   Undefined -> counters and their ports are absent.
// ----------------------------------------------------------------------------

module demux2_router #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    demux2_in_if.slave        in_if,
    demux2_out_if.master      a_if,
    demux2_out_if.master      b_if
`ifdef DEMUX2_ROUTER_COUNT_EN
    ,
    output logic [15:0]       a_count,
    output logic [15:0]       b_count
`endif
);

    localparam int unsigned CW = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_t;

    port_state_t   a_state;
    port_state_t   b_state;
    logic [DW-1:0] a_data_q;
    logic [AW-1:0] a_addr_q;
    logic [DW-1:0] b_data_q;
    logic [AW-1:0] b_addr_q;

    logic a_full_c;
    logic b_full_c;
    logic a_take_c;
    logic b_take_c;
    logic in_ready_c;
    logic in_xfer_c;
    logic load_a_c;
    logic load_b_c;

    // Port occupancy and sink transfers
    assign a_full_c = (a_state == FULL);
    assign b_full_c = (b_state == FULL);
    assign a_take_c = a_full_c & a_if.ready;
    assign b_take_c = b_full_c & b_if.ready;

    // Accept when the selected port is empty or is being drained this cycle
    assign in_ready_c = ~reset & (in_if.select ? (~b_full_c | b_if.ready)
                                               : (~a_full_c | a_if.ready));
    assign in_xfer_c  = in_if.valid & in_ready_c;
    assign load_a_c   = in_xfer_c & ~in_if.select;
    assign load_b_c   = in_xfer_c &  in_if.select;

    // Per-port EMPTY/FULL state machines with their held words
    always_ff @(posedge clk) begin
        if (reset) begin
            a_state  <= EMPTY;
            b_state  <= EMPTY;
            a_data_q <= '0;
            a_addr_q <= '0;
            b_data_q <= '0;
            b_addr_q <= '0;
        end else begin
            case (a_state)
                EMPTY:   if (load_a_c) a_state <= FULL;
                FULL:    if (a_if.ready && !load_a_c) a_state <= EMPTY;
                default: a_state <= EMPTY;
            endcase

            case (b_state)
                EMPTY:   if (load_b_c) b_state <= FULL;
                FULL:    if (b_if.ready && !load_b_c) b_state <= EMPTY;
                default: b_state <= EMPTY;
            endcase

            // A load into a FULL port only happens when its sink takes the old word
            if (load_a_c) begin
                a_data_q <= in_if.data;
                a_addr_q <= in_if.addr;
            end
            if (load_b_c) begin
                b_data_q <= in_if.data;
                b_addr_q <= in_if.addr;
            end
        end
    end

`ifdef DEMUX2_ROUTER_COUNT_EN
    // Sink-transfer counters; reset cycles never count
    always_ff @(posedge clk) begin
        if (reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_take_c) a_count <= a_count + CW'(1);
            if (b_take_c) b_count <= b_count + CW'(1);
        end
    end
`else
    // Sink transfers only feed the optional counters
    logic unused_take_c;
    assign unused_take_c = a_take_c ^ b_take_c ^ (CW != 0);
`endif

    assign in_if.ready = in_ready_c;

    assign a_if.valid  = a_full_c;
    assign a_if.data   = a_data_q;
    assign a_if.addr   = a_addr_q;

    assign b_if.valid  = b_full_c;
    assign b_if.data   = b_data_q;
    assign b_if.addr   = b_addr_q;

endmodule
